mat_vec_mul_ctrl: RTL and testbench

Sequencer that computes a full Saber matrix-vector product b = A·s (or Aᵀ·s) on the shared polynomial multiplier/accumulator. For each of L output rows it:
- clears the accumulator;
- runs L multiply-accumulate passes, steering the matrix-element and secret-polynomial selects;
- streams the 2^WORD_W accumulated coefficients into the result memory at a row-indexed base address.

It sits between the top-level instruction decoder (start/done) and the polynomial multiplier, replacing per-row hand sequencing.

---
 rtl/mat_vec_mul_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mat_vec_mul_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_vec_mul_ctrl.sv
// Sequencer for a Saber matrix-vector product b = A*s or A^T*s on the shared
// polynomial multiplier/accumulator: clear, L MAC passes, stream one result row.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; multiplier and accumulator held cleared
// CLEAR | one cycle, accumulator cleared for the new output row
// LOAD  | one cycle, selects for (row, col) settle before the pass runs
// MUL   | multiplier running until pol_mul_done
// WRITE | stream 2^WORD_W accumulator words to result memory {row, word}
// DONE  | one-cycle completion pulse
module mat_vec_mul_ctrl #(
    parameter int L      = 3,
    parameter int WORD_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              transpose,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rst_pol_mul,
    output logic              pol_acc_clear,
    output logic [1:0]        pol_base_sel,
    output logic [3:0]        mat_sel,
    input  logic              pol_mul_done,
    output logic              result_read,
    output logic              res_wen,
    output logic [WORD_W+1:0] res_addr
);

    localparam logic [1:0]        LAST_IDX  = 2'(L - 1);
    localparam logic [3:0]        RANK      = 4'(L);
    localparam logic [WORD_W-1:0] LAST_WORD = '1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        MUL,
        WRITE,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        row, row_nxt;
    logic [1:0]        col, col_nxt;
    logic [WORD_W-1:0] word, word_nxt;
    logic              t_reg, t_nxt;
    logic [3:0]        elem_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
            word  <= '0;
            t_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
            word  <= word_nxt;
            t_reg <= t_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        word_nxt  = word;
        t_nxt     = t_reg;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    t_nxt     = transpose;
                    row_nxt   = '0;
                    col_nxt   = '0;
                    word_nxt  = '0;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: state_nxt = LOAD;
            LOAD:  state_nxt = MUL;
            MUL: begin
                if (pol_mul_done) begin
                    if (col == LAST_IDX) begin
                        state_nxt = WRITE;
                    end else begin
                        col_nxt   = col + 2'd1;
                        state_nxt = LOAD;
                    end
                end
            end
            WRITE: begin
                // word wraps to zero naturally after the last address of the row
                word_nxt = word + WORD_W'(1);
                if (word == LAST_WORD) begin
                    if (row == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        row_nxt   = row + 2'd1;
                        col_nxt   = '0;
                        state_nxt = CLEAR;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // abort outranks every pass and row transition; the current WRITE still lands
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    assign elem_idx = t_reg ? (({2'b00, col} * RANK) + {2'b00, row})
                            : (({2'b00, row} * RANK) + {2'b00, col});

    always_comb begin
        busy          = 1'b1;
        done          = 1'b0;
        rst_pol_mul   = 1'b1;
        pol_acc_clear = 1'b0;
        pol_base_sel  = '0;
        mat_sel       = '0;
        result_read   = 1'b0;
        res_wen       = 1'b0;
        res_addr      = '0;
        case (state)
            IDLE: begin
                busy          = 1'b0;
                pol_acc_clear = 1'b1;
            end
            CLEAR: begin
                pol_acc_clear = 1'b1;
                pol_base_sel  = col;
                mat_sel       = elem_idx;
            end
            LOAD: begin
                pol_base_sel = col;
                mat_sel      = elem_idx;
            end
            MUL: begin
                rst_pol_mul  = 1'b0;
                pol_base_sel = col;
                mat_sel      = elem_idx;
            end
            WRITE: begin
                pol_base_sel = col;
                mat_sel      = elem_idx;
                result_read  = 1'b1;
                res_wen      = 1'b1;
                res_addr     = {row, word};
            end
            DONE: begin
                done          = 1'b1;
                pol_acc_clear = 1'b1;
            end
            default: begin
                busy          = 1'b0;
                pol_acc_clear = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mat_vec_mul_ctrl.sv
// Bench for mat_vec_mul_ctrl: a per-cycle schedule of expected outputs is built
// from the product's pass structure and checked every cycle, plus literal pins.
module tb_mat_vec_mul_ctrl;

    localparam int L      = 3;
    localparam int WORD_W = 6;
    localparam int NW     = 1 << WORD_W;

    typedef struct packed {
        logic       bsy;
        logic       dn;
        logic       rpm;
        logic       clr;
        logic       rr;
        logic       wen;
        logic [1:0] pbs;
        logic [3:0] ms;
        logic [7:0] addr;
    } out_t;

    typedef struct {
        out_t o;
        logic pmd;
        logic abt;
        logic rsth;
    } entry_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              transpose;
    logic              abort;
    logic              busy;
    logic              done;
    logic              rst_pol_mul;
    logic              pol_acc_clear;
    logic [1:0]        pol_base_sel;
    logic [3:0]        mat_sel;
    logic              pol_mul_done;
    logic              result_read;
    logic              res_wen;
    logic [WORD_W+1:0] res_addr;

    mat_vec_mul_ctrl #(.L(L), .WORD_W(WORD_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .transpose    (transpose),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .rst_pol_mul  (rst_pol_mul),
        .pol_acc_clear(pol_acc_clear),
        .pol_base_sel (pol_base_sel),
        .mat_sel      (mat_sel),
        .pol_mul_done (pol_mul_done),
        .result_read  (result_read),
        .res_wen      (res_wen),
        .res_addr     (res_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    entry_t     q[$];
    int         cyc      = 0;
    int         wr_cnt   = 0;
    int         last_wr  = -1;
    int         done_cnt = 0;
    int         done_cyc = -1;
    logic [3:0] ms_log[$];
    logic [1:0] pbs_log[$];

    int exp_norm [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    int exp_tr   [9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
    int exp_pbs  [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic out_t idle_o();
        out_t o = '0;
        o.rpm = 1'b1;
        o.clr = 1'b1;
        return o;
    endfunction

    function automatic out_t pass_o(input bit rpm, input bit clr, input int r, input int c,
                                    input bit tr);
        out_t o = '0;
        o.bsy = 1'b1;
        o.rpm = rpm;
        o.clr = clr;
        o.pbs = 2'(c);
        o.ms  = 4'(tr ? c * L + r : r * L + c);
        return o;
    endfunction

    function automatic entry_t mk(input out_t o, input bit pmd, input bit abt, input bit rsth);
        entry_t e;
        e.o    = o;
        e.pmd  = pmd;
        e.abt  = abt;
        e.rsth = rsth;
        return e;
    endfunction

    // Expected schedule of one product, starting with the cycle where start is high.
    task automatic build(input int k, input bit tr, input bit noise, input int ab_row,
                         input int ab_word, input int rs_row, input int rs_col, input int rs_m);
        out_t o;
        q.push_back(mk(idle_o(), noise, 1'b0, 1'b0));
        for (int r = 0; r < L; r++) begin
            q.push_back(mk(pass_o(1'b1, 1'b1, r, 0, tr), noise, 1'b0, 1'b0));
            for (int c = 0; c < L; c++) begin
                q.push_back(mk(pass_o(1'b1, 1'b0, r, c, tr), noise, 1'b0, 1'b0));
                for (int m = 0; m < k; m++)
                    q.push_back(mk(pass_o(1'b0, 1'b0, r, c, tr), (m == k - 1), 1'b0,
                                   (r == rs_row && c == rs_col && m == rs_m)));
            end
            for (int w = 0; w < NW; w++) begin
                o      = pass_o(1'b1, 1'b0, r, L - 1, tr);
                o.rr   = 1'b1;
                o.wen  = 1'b1;
                o.addr = 8'(r * NW + w);
                if (r == ab_row && w == ab_word) begin
                    q.push_back(mk(o, 1'b0, 1'b1, 1'b0));
                    return;
                end
                q.push_back(mk(o, noise, 1'b0, 1'b0));
            end
        end
        o     = idle_o();
        o.bsy = 1'b1;
        o.dn  = 1'b1;
        q.push_back(mk(o, noise, 1'b0, 1'b0));
    endtask

    // Single compare process: every cycle, DUT outputs vs the schedule head (idle when empty).
    initial begin
        entry_t e;
        out_t   req;
        out_t   act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                req = e.o;
            end else begin
                req = idle_o();
            end
            act = {busy, done, rst_pol_mul, pol_acc_clear, result_read, res_wen,
                   pol_base_sel, mat_sel, res_addr};
            chk($sformatf("cycle%0d_outputs", cyc), 32'(act), 32'(req));
            if (res_wen) begin
                wr_cnt++;
                last_wr = int'(res_addr);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy && rst_pol_mul && !pol_acc_clear && !res_wen) begin
                ms_log.push_back(mat_sel);
                pbs_log.push_back(pol_base_sel);
            end
            cyc++;
        end
    end

    task automatic run_product(input bit tr, input int k, input bit noise, input bit toggle,
                               input int ab_row, input int ab_word, input int rs_row,
                               input int rs_col, input int rs_m, output int start_cyc);
        int n;
        out_t act;
        build(k, tr, noise, ab_row, ab_word, rs_row, rs_col, rs_m);
        start        = 1'b1;
        transpose    = tr;
        abort        = 1'b0;
        pol_mul_done = q[0].pmd;
        start_cyc    = cyc;
        n            = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) break;
            n++;
            if (n > 2000) begin
                chk("run_budget_expired", 32'(q.size()), 32'd0);
                q.delete();
                break;
            end
            pol_mul_done = q[0].pmd;
            abort        = q[0].abt;
            start        = (toggle && q.size() > 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (toggle) transpose = 1'($urandom_range(0, 1));
            if (q[0].rsth) begin
                chk("busy_before_reset", 32'(busy), 32'd1);
                rst_n = 1'b0;
                #1;
                act = {busy, done, rst_pol_mul, pol_acc_clear, result_read, res_wen,
                       pol_base_sel, mat_sel, res_addr};
                chk("async_reset_outputs", 32'(act), 32'h0003_0000);
                q.delete();
                break;
            end
        end
        start        = 1'b0;
        pol_mul_done = 1'b0;
        abort        = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int   sc;
        int   wr0;
        int   dn0;
        int   lg0;
        out_t act;
        rst_n        = 1'b0;
        start        = 1'b0;
        transpose    = 1'b0;
        abort        = 1'b0;
        pol_mul_done = 1'b0;
        #3;
        act = {busy, done, rst_pol_mul, pol_acc_clear, result_read, res_wen,
               pol_base_sel, mat_sel, res_addr};
        chk("reset_outputs", 32'(act), 32'h0003_0000);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(10);
        chk("idle_after_release_busy", 32'(busy), 32'd0);

        // normal product, pol_mul_done on the 10th MUL cycle
        wr0 = wr_cnt; dn0 = done_cnt; lg0 = ms_log.size();
        run_product(1'b0, 10, 1'b0, 1'b0, -1, -1, -1, -1, -1, sc);
        idle_cycles(2);
        chk("normal_done_offset", 32'(done_cyc - sc), 32'd295);
        chk("normal_write_count", 32'(wr_cnt - wr0), 32'd192);
        chk("normal_last_addr", 32'(last_wr), 32'd191);
        chk("normal_done_count", 32'(done_cnt - dn0), 32'd1);
        chk("normal_pass_count", 32'(ms_log.size() - lg0), 32'd9);
        if (ms_log.size() - lg0 == 9)
            for (int i = 0; i < 9; i++)
                chk($sformatf("normal_mat_sel%0d", i), 32'(ms_log[lg0 + i]), 32'(exp_norm[i]));

        // transpose product
        dn0 = done_cnt; lg0 = ms_log.size();
        run_product(1'b1, 10, 1'b0, 1'b0, -1, -1, -1, -1, -1, sc);
        idle_cycles(2);
        chk("tr_done_offset", 32'(done_cyc - sc), 32'd295);
        chk("tr_done_count", 32'(done_cnt - dn0), 32'd1);
        chk("tr_pass_count", 32'(ms_log.size() - lg0), 32'd9);
        if (ms_log.size() - lg0 == 9)
            for (int i = 0; i < 9; i++) begin
                chk($sformatf("tr_mat_sel%0d", i), 32'(ms_log[lg0 + i]), 32'(exp_tr[i]));
                chk($sformatf("tr_pol_base_sel%0d", i), 32'(pbs_log[lg0 + i]), 32'(exp_pbs[i]));
            end

        // immediate pol_mul_done, stray pol_mul_done outside MUL, start toggling while busy
        wr0 = wr_cnt; dn0 = done_cnt;
        run_product(1'b0, 1, 1'b1, 1'b1, -1, -1, -1, -1, -1, sc);
        idle_cycles(2);
        chk("late_done_offset", 32'(done_cyc - sc), 32'd214);
        chk("late_write_count", 32'(wr_cnt - wr0), 32'd192);
        chk("late_done_count", 32'(done_cnt - dn0), 32'd1);

        // abort in WRITE of row 1 at word 10
        wr0 = wr_cnt; dn0 = done_cnt;
        run_product(1'b0, 4, 1'b0, 1'b0, 1, 10, -1, -1, -1, sc);
        idle_cycles(3);
        chk("abort_write_count", 32'(wr_cnt - wr0), 32'd75);
        chk("abort_last_addr", 32'(last_wr), 32'd74);
        chk("abort_done_count", 32'(done_cnt - dn0), 32'd0);
        chk("abort_busy_after", 32'(busy), 32'd0);

        dn0 = done_cnt;
        run_product(1'b0, 2, 1'b0, 1'b0, -1, -1, -1, -1, -1, sc);
        idle_cycles(2);
        chk("post_abort_done_offset", 32'(done_cyc - sc), 32'd223);
        chk("post_abort_done_count", 32'(done_cnt - dn0), 32'd1);

        // async reset during MUL of row 2, then a fresh product
        dn0 = done_cnt;
        run_product(1'b0, 10, 1'b0, 1'b0, -1, -1, 2, 1, 4, sc);
        idle_cycles(2);
        chk("reset_run_done_count", 32'(done_cnt - dn0), 32'd0);
        rst_n = 1'b1;
        idle_cycles(2);
        dn0 = done_cnt; wr0 = wr_cnt;
        run_product(1'b1, 3, 1'b0, 1'b0, -1, -1, -1, -1, -1, sc);
        idle_cycles(2);
        chk("post_reset_done_offset", 32'(done_cyc - sc), 32'd232);
        chk("post_reset_write_count", 32'(wr_cnt - wr0), 32'd192);
        chk("post_reset_done_count", 32'(done_cnt - dn0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
